// File: rtl/vx_mem_responder_pkg.sv
// Shared constants for the memory responder: minimum read latency and perf counter width.
// Also holds a small sizing helper used by the response queue.
package vx_mem_responder_pkg;

  localparam int MIN_LATENCY   = 1;
  localparam int PERF_CTR_BITS = 32;

  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vx_mem_responder_rsp_queue.sv
// In-order response FIFO for the memory responder.
// A pop frees its slot in the same cycle, so a full queue accepts a push if it also pops.
module vx_mem_responder_rsp_queue
  import vx_mem_responder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_bits(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr_q] <= push_data;
  end

  assign head_data = store_q[rd_ptr_q];

endmodule

// File: rtl/vx_mem_responder.sv
// On-chip backing store behind the Vortex memory port: byte-enabled writes, fixed-latency
// tagged in-order reads. Define MEM_RESPONDER_PERF_EN to add read/write/stall counters.
module vx_mem_responder
  import vx_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = 8,
  parameter int MEM_LINES_LOG2 = 10,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready
`ifdef MEM_RESPONDER_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_reads,
  output logic [PERF_CTR_BITS-1:0] perf_writes,
  output logic [PERF_CTR_BITS-1:0] perf_stall_cycles
`endif
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready; valid never
  // waits on ready, and the presenter holds valid and payload stable until the transfer.

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LINES  = 1 << MEM_LINES_LOG2;
  localparam int PEND_W = $clog2(RSP_QUEUE_SIZE + 1);
  localparam int STAGES = LATENCY - 1;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } rsp_entry_t;

  if (LATENCY < MIN_LATENCY) begin : g_bad_latency
    $error("vx_mem_responder: LATENCY must be >= 1");
  end
  if ((RSP_QUEUE_SIZE < 2) || ((RSP_QUEUE_SIZE & (RSP_QUEUE_SIZE - 1)) != 0)) begin : g_bad_queue
    $error("vx_mem_responder: RSP_QUEUE_SIZE must be a power of 2 and >= 2");
  end
  if (MEM_LINES_LOG2 > ADDR_WIDTH) begin : g_bad_lines
    $error("vx_mem_responder: MEM_LINES_LOG2 must be <= ADDR_WIDTH");
  end

  logic                      rst_done_q, rst_done_d;
  logic [PEND_W-1:0]         pending_q, pending_d;
  logic                      req_fire, rd_fire, wr_fire, rsp_fire;
  logic [MEM_LINES_LOG2-1:0] mem_idx;
  logic [DATA_WIDTH-1:0]     store_q [LINES];
  rsp_entry_t                s0_entry, push_entry, head_entry;
  logic                      push_vld, q_full, q_empty;

  assign rst_done_d    = 1'b1;
  assign mem_req_ready = rst_done_q && (pending_q < PEND_W'(RSP_QUEUE_SIZE));
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rd_fire       = req_fire && !mem_req_rw;
  assign wr_fire       = req_fire && mem_req_rw;
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
  assign mem_idx       = mem_req_addr[MEM_LINES_LOG2-1:0];

  if (MEM_LINES_LOG2 < ADDR_WIDTH) begin : g_addr_alias
    logic addr_hi_unused;
    assign addr_hi_unused = ^mem_req_addr[ADDR_WIDTH-1:MEM_LINES_LOG2];
  end

  // A queue slot is reserved at read accept, so this counter covers pipeline + FIFO.
  always_comb begin
    pending_d = pending_q;
    if (rd_fire && !rsp_fire) pending_d = pending_q + PEND_W'(1);
    if (!rd_fire && rsp_fire) pending_d = pending_q - PEND_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_done_q <= 1'b0;
      pending_q  <= '0;
    end else begin
      rst_done_q <= rst_done_d;
      pending_q  <= pending_d;
    end
  end

  // Storage is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < BYTES; i++) begin
        if (mem_req_byteen[i]) store_q[mem_idx][i*8 +: 8] <= mem_req_data[i*8 +: 8];
      end
    end
  end

  assign s0_entry.tag  = mem_req_tag;
  assign s0_entry.data = store_q[mem_idx];

  // The FIFO register is the last latency stage, so only LATENCY-1 shift stages precede it.
  if (STAGES == 0) begin : g_no_pipe
    assign push_vld   = rd_fire;
    assign push_entry = s0_entry;
  end else begin : g_pipe
    logic [STAGES-1:0] vld_q, vld_d;
    rsp_entry_t        ent_q [STAGES];
    rsp_entry_t        ent_d [STAGES];

    always_comb begin
      vld_d[0] = rd_fire;
      ent_d[0] = s0_entry;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        ent_d[i] = ent_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) vld_q <= '0;
      else        vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
      ent_q <= ent_d;
    end

    assign push_vld   = vld_q[STAGES-1];
    assign push_entry = ent_q[STAGES-1];
  end

  vx_mem_responder_rsp_queue #(
    .WIDTH ($bits(rsp_entry_t)),
    .DEPTH (RSP_QUEUE_SIZE)
  ) u_rsp_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push_vld),
    .push_data (push_entry),
    .pop       (rsp_fire),
    .head_data (head_entry),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign mem_rsp_valid = !q_empty;
  assign mem_rsp_data  = mem_rsp_valid ? head_entry.data : '0;
  assign mem_rsp_tag   = mem_rsp_valid ? head_entry.tag  : '0;

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(rsp_fire && !rd_fire && (pending_q == '0)));
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    pending_q <= PEND_W'(RSP_QUEUE_SIZE));
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    !(push_vld && q_full && !rsp_fire));

`ifdef MEM_RESPONDER_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_reads_q, perf_reads_d;
  logic [PERF_CTR_BITS-1:0] perf_writes_q, perf_writes_d;
  logic [PERF_CTR_BITS-1:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_reads_d  = perf_reads_q;
    perf_writes_d = perf_writes_q;
    perf_stall_d  = perf_stall_q;
    if (rd_fire) perf_reads_d  = perf_reads_q + PERF_CTR_BITS'(1);
    if (wr_fire) perf_writes_d = perf_writes_q + PERF_CTR_BITS'(1);
    if (mem_req_valid && !mem_req_ready) perf_stall_d = perf_stall_q + PERF_CTR_BITS'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_reads_q  <= '0;
      perf_writes_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_reads_q  <= perf_reads_d;
      perf_writes_q <= perf_writes_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_reads        = perf_reads_q;
  assign perf_writes       = perf_writes_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed scoreboard bench for vx_mem_responder: reads push expected {tag,data} into a queue
// and an independent monitor pops and compares on every response handshake.
module tb_vx_mem_responder;

  localparam int DW = 512;
  localparam int AW = 26;
  localparam int TW = 8;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req_valid;
  logic          mem_req_rw;
  logic [BW-1:0] mem_req_byteen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready;
`ifdef MEM_RESPONDER_PERF_EN
  logic [31:0]   perf_reads, perf_writes, perf_stall_cycles;
`endif

  vx_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready)
`ifdef MEM_RESPONDER_PERF_EN
    ,
    .perf_reads        (perf_reads),
    .perf_writes       (perf_writes),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [TW+DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int stall_cnt = 0;

  logic [DW-1:0] line_a5, line_ff, line_zero, line_b0, line_beef;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic rw, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                        input logic [DW-1:0] data, input logic [TW-1:0] tag,
                        input logic [DW-1:0] exp, output int waited);
    @(negedge clk);
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = addr;
    mem_req_byteen = be;
    mem_req_data   = data;
    mem_req_tag    = tag;
    waited = 0;
    #1;
    while (!mem_req_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!mem_req_ready) begin
      timeout_fail("req_accept");
    end else if (rw) begin
      wr_cnt++;
    end else begin
      rd_cnt++;
      exp_q.push_back({tag, exp});
    end
    @(posedge clk);
    #1;
    mem_req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) timeout_fail("drain");
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [TW+DW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        if (mem_req_valid && !mem_req_ready) stall_cnt++;
        if (mem_rsp_valid && mem_rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got tag %0h, expected no response", mem_rsp_tag);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_tag", DW'(mem_rsp_tag), DW'(e[TW+DW-1:DW]));
            chk("rsp_data", mem_rsp_data, e[DW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int ok_low;
    int seen;
    line_a5   = {64{8'hA5}};
    line_ff   = {64{8'hFF}};
    line_zero = '0;
    line_b0   = 512'hFF;
    line_beef = {16{32'hDEADBEEF}};

    reset          = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_byteen = '0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_tag    = '0;
    mem_rsp_ready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", DW'(mem_req_ready), 0);
    chk("rst_rsp_valid", DW'(mem_rsp_valid), 0);
    chk("rst_rsp_data", mem_rsp_data, 0);
    chk("rst_rsp_tag", DW'(mem_rsp_tag), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_rst", DW'(mem_req_ready), 1);

    // Full-line write then read next cycle; response exactly LATENCY cycles later
    do_req(1'b1, 26'h10, '1, line_a5, 8'h0, line_zero, w);
    do_req(1'b0, 26'h10, '0, line_zero, 8'h3, line_a5, w);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("latency_valid_c%0d", k), DW'(mem_rsp_valid), (k == 4) ? 1 : 0);
    end
    wait_drain();

    // Partial byte write onto a zeroed line
    do_req(1'b1, 26'h20, '1, line_zero, 8'h0, line_zero, w);
    do_req(1'b1, 26'h20, 64'h1, line_ff, 8'h0, line_zero, w);
    do_req(1'b0, 26'h20, '0, line_zero, 8'h7, line_b0, w);
    // byteen=0 write is a no-op
    do_req(1'b1, 26'h20, '0, line_a5, 8'h0, line_zero, w);
    do_req(1'b0, 26'h20, '0, line_zero, 8'h8, line_b0, w);
    wait_drain();

    // Credit limit: 4 reads back to back with consumer stalled, 5th blocked
    @(negedge clk);
    mem_rsp_ready = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      do_req(1'b0, (t % 2) ? 26'h10 : 26'h20, '0, line_zero, TW'(t),
             (t % 2) ? line_a5 : line_b0, w);
      chk($sformatf("b2b_accept_t%0d", t), DW'(w), 0);
    end
    @(negedge clk);
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 26'h10;
    mem_req_tag   = 8'h5;
    ok_low = 1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (mem_req_ready) ok_low = 0;
      @(negedge clk);
    end
    chk("ready_low_when_full", DW'(ok_low), 1);
    chk("head_tag_held", DW'({mem_rsp_valid, mem_rsp_tag}), DW'({1'b1, 8'h1}));
    mem_rsp_ready = 1'b1;
    #1;
    chk("ready_low_pop_cycle", DW'(mem_req_ready), 0);
    @(negedge clk);
    #1;
    chk("ready_high_after_pop", DW'(mem_req_ready), 1);
    if (mem_req_ready) begin
      rd_cnt++;
      exp_q.push_back({8'h5, line_a5});
    end
    @(posedge clk);
    #1;
    mem_req_valid = 1'b0;
    wait_drain();

    // Address aliasing: 0x400 maps onto line 0
    do_req(1'b1, 26'h400, '1, line_beef, 8'h0, line_zero, w);
    do_req(1'b0, 26'h000, '0, line_zero, 8'h9, line_beef, w);
    wait_drain();

    // Asynchronous reset with reads in flight
    @(negedge clk);
    mem_rsp_ready = 1'b0;
    do_req(1'b0, 26'h10, '0, line_zero, 8'hA, line_a5, w);
    do_req(1'b0, 26'h20, '0, line_zero, 8'hB, line_b0, w);
    do_req(1'b0, 26'h00, '0, line_zero, 8'hC, line_beef, w);
    w = 0;
    while (!mem_rsp_valid && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!mem_rsp_valid) timeout_fail("inflight_valid");
    @(negedge clk);
    #3;
    reset = 1'b0;
    exp_q.delete();
    rd_cnt = 0;
    wr_cnt = 0;
    stall_cnt = 0;
    #1;
    chk("async_rst_rsp_valid", DW'(mem_rsp_valid), 0);
    chk("async_rst_req_ready", DW'(mem_req_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_rsp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (mem_rsp_valid) seen++;
    end
    chk("no_stale_rsp", DW'(seen), 0);
    do_req(1'b0, 26'h10, '0, line_zero, 8'hD, line_a5, w);
    do_req(1'b0, 26'h20, '0, line_zero, 8'hE, line_b0, w);
    do_req(1'b0, 26'h400, '0, line_zero, 8'hF, line_beef, w);
    wait_drain();

`ifdef MEM_RESPONDER_PERF_EN
    repeat (2) @(negedge clk);
    #1;
    chk("perf_reads", DW'(perf_reads), DW'(rd_cnt));
    chk("perf_writes", DW'(perf_writes), DW'(wr_cnt));
    chk("perf_stall_cycles", DW'(perf_stall_cycles), DW'(stall_cnt));
`endif

    repeat (4) @(negedge clk);
    chk("final_queue_empty", DW'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
